cok_cevrimli_islemci: RTL and testbench
=======================================

Name: cok_cevrimli_islemci

Overview:
- 32-bit RV32I multicycle processor core. Executes each instruction in exactly three cycles: fetch, decode/register-read, execute/writeback.
- Connects to a single unified word memory (the team's `anabellek`) through one address bus, one read-data bus, one write-data bus and one write strobe.
- Instructions and data share the bus; the PC starts at 0x8000_0000.

Parameters:
- BASLANGIC_ADRES, 32'h8000_0000, PC value after reset.
- ADRES_BIT, 32, address width.
- VERI_BIT, 32, data/instruction width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bellek_adres  out  32  memory byte address: PC in fetch, load/store address in execute, else PC.
- bellek_oku_veri  in  32  memory read data; combinational (same-cycle) with bellek_adres.
- bellek_yaz_veri  out  32  store data (rs2 value); 0 when not storing.
- bellek_yaz  out  1  write strobe; memory writes bellek_yaz_veri at bellek_adres on the rising edge where it is high.

Behaviour:
- Stage register `simdiki_asama_r` [1:0], encoded by localparams GETIR=2'd0, COZYAZMACOKU=2'd1, YURUTGERIYAZ=2'd2. These are hierarchically visible names.
- Stage sequence: GETIR -> COZYAZMACOKU -> YURUTGERIYAZ -> GETIR, unconditionally. Value 2'd3 is illegal and recovers to GETIR.
- Register file `yazmac_obegi[0:31]`, 32 bits each, hierarchically visible.
  - x0 reads 0 and is never written.
- Reset (async, active-high), while rst is high:
  - PC = BASLANGIC_ADRES, stage = GETIR.
  - Instruction and operand latches = 0.
  - All registers = 0.
  - bellek_yaz = 0, bellek_yaz_veri = 0.
- Reset asserted mid-instruction aborts the instruction with no register or memory write. After release, the first rising edge is the GETIR edge.
- GETIR: bellek_adres = PC; the instruction register latches bellek_oku_veri at the clock edge.
- COZYAZMACOKU:
  - Decode opcode/funct3/funct7/rd.
  - Read rs1 and rs2 into operand latches.
  - Generate the sign-extended immediate (I/S/B/U/J formats) into a latch.
- YURUTGERIYAZ:
  - ALU computes the result.
  - Loads and stores drive the effective address rs1+imm on bellek_adres. A store asserts bellek_yaz.
  - rd is written at the edge ending this stage.
  - PC is updated at the same edge: PC+4, or the branch/jump target.
- Supported instructions:
  - LUI: rd = imm[31:12]<<12.
  - AUIPC: rd = PC_of_instr + (imm<<12), modulo 2^32.
  - JAL and JALR: rd = PC+4. The JALR target has bit 0 cleared.
  - Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU, target PC+imm.
  - LW and SW, word only. Address bits [1:0] are ignored.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Arithmetic: all 32-bit with wrap-around. Shift amount is the low 5 bits. Signed compares are two's complement.
- Unsupported or unknown opcodes execute as NOP: no write, PC+4, still three cycles.

Decomposition:
- Shared package `islemci_pkg`:
  - stage encodings (GETIR, COZYAZMACOKU, YURUTGERIYAZ);
  - RV32I opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP);
  - funct3 constants;
  - ALU operation enum.
- The stage localparams must also be visible inside the core.
- One natural sub-module, `islemci_alu`: combinational, inputs a, b and an op code, output a 32-bit result plus a branch-condition flag.
- The register file and stage FSM stay in the top module.

Test Plan:
- Reset 10 cycles, release → stage check per instruction: GETIR, COZYAZMACOKU, YURUTGERIYAZ on three consecutive cycles, repeated for every instruction.
- addi x17,x0,-1362 (0xAAE00893); addi x29,x0,370 (0x17200E93) → after 6 cycles x17=0xFFFFFAAE, x29=370.
- lui x12,0x52AE9 (0x52AE9637); lui x9,0xAC740 (0xAC7404B7) → x12=0x52AE9000, x9=0xAC740000.
- auipc x4 at 0x8000_0010 (0xAB7B6217); auipc x3 at 0x8000_0014 (0x56ECA197) → x4=0x2B7B6010, x3=0xD6ECA014.
- sw x17,0(x5) with x5=0x8000_0100, then lw x6,0(x5):
  - bellek_yaz is high only in the store's YURUTGERIYAZ stage;
  - memory word = 0xFFFFFAAE;
  - x6 = 0xFFFFFAAE.
- beq x0,x0,+8, then jal x1,-4; plus an addi targeting x0 → PC skips one word, x1 = PC+4, and x0 stays 0. Asserting rst mid-COZYAZMACOKU returns PC to 0x8000_0000 with no write.

Source files
------------

// File: rtl/cok_cevrimli_islemci_pkg.sv
// Shared definitions for the multicycle RV32I core: stage codes, opcodes,
// funct3 values, ALU operations and the immediate generator.
package islemci_pkg;

    typedef enum logic [1:0] {
        ASAMA_GETIR        = 2'd0,
        ASAMA_COZYAZMACOKU = 2'd1,
        ASAMA_YURUTGERIYAZ = 2'd2
    } asama_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
    } alu_op_e;

    // alt selects SUB/SRA; callers pass it only where funct7 bit 30 is meaningful.
    function automatic logic [3:0] alu_op_sec(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] imm_uret(input logic [31:0] k);
        logic [31:0] imm;
        case (k[6:0])
            OPC_STORE:           imm = {{20{k[31]}}, k[31:25], k[11:7]};
            OPC_BRANCH:          imm = {{19{k[31]}}, k[31], k[7], k[30:25], k[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:  imm = {k[31:12], 12'b0};
            OPC_JAL:             imm = {{11{k[31]}}, k[31], k[19:12], k[20], k[30:21], 1'b0};
            default:             imm = {{20{k[31]}}, k[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/cok_cevrimli_islemci_alu.sv
// Combinational ALU: arithmetic/logic result plus the branch-condition flag.
module islemci_alu
    import islemci_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] sonuc,
    output logic        dallan
);

    always_comb begin
        sonuc  = '0;
        dallan = 1'b0;
        case (op)
            ALU_ADD:  sonuc = a + b;
            ALU_SUB:  sonuc = a - b;
            ALU_SLL:  sonuc = a << b[4:0];
            ALU_SLT:  sonuc = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: sonuc = {31'b0, a < b};
            ALU_XOR:  sonuc = a ^ b;
            ALU_SRL:  sonuc = a >> b[4:0];
            ALU_SRA:  sonuc = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   sonuc = a | b;
            ALU_AND:  sonuc = a & b;
            ALU_BEQ:  dallan = (a == b);
            ALU_BNE:  dallan = (a != b);
            ALU_BLT:  dallan = ($signed(a) < $signed(b));
            ALU_BGE:  dallan = ($signed(a) >= $signed(b));
            ALU_BLTU: dallan = (a < b);
            ALU_BGEU: dallan = (a >= b);
            default:  ;
        endcase
    end

endmodule

// File: rtl/cok_cevrimli_islemci.sv
// RV32I core, three cycles per instruction (fetch, decode/read, execute/writeback)
// on a single shared word memory bus.
module cok_cevrimli_islemci
    import islemci_pkg::*;
#(
    parameter logic [31:0] BASLANGIC_ADRES = 32'h8000_0000,
    parameter int          ADRES_BIT       = 32,
    parameter int          VERI_BIT        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADRES_BIT-1:0] bellek_adres,
    input  logic [VERI_BIT-1:0]  bellek_oku_veri,
    output logic [VERI_BIT-1:0]  bellek_yaz_veri,
    output logic                 bellek_yaz
);

    localparam logic [1:0] GETIR        = ASAMA_GETIR;
    localparam logic [1:0] COZYAZMACOKU = ASAMA_COZYAZMACOKU;
    localparam logic [1:0] YURUTGERIYAZ = ASAMA_YURUTGERIYAZ;

    logic [1:0]  simdiki_asama_r;
    logic [31:0] pc_r, komut_r, rs1_r, rs2_r, imm_r;
    logic [31:0] yazmac_obegi [0:31];

    logic [6:0]  opkod;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_sonuc;
    logic        alu_dallan;
    logic        rd_yaz, bellek_erisim;
    logic [31:0] rd_veri, sonraki_pc, pc_arti4;

    assign opkod    = komut_r[6:0];
    assign f3       = komut_r[14:12];
    assign rd       = komut_r[11:7];
    assign pc_arti4 = pc_r + 32'd4;

    always_comb begin
        alu_a  = rs1_r;
        alu_b  = imm_r;
        alu_op = ALU_ADD;
        case (opkod)
            OPC_LUI:    alu_a = '0;
            OPC_AUIPC:  alu_a = pc_r;
            OPC_OP: begin
                alu_b  = rs2_r;
                alu_op = alu_op_sec(f3, komut_r[30]);
            end
            OPC_OP_IMM: alu_op = alu_op_sec(f3, komut_r[30] && (f3 == F3_SRL_SRA));
            OPC_BRANCH: begin
                alu_b = rs2_r;
                case (f3)
                    F3_BEQ:  alu_op = ALU_BEQ;
                    F3_BNE:  alu_op = ALU_BNE;
                    F3_BLT:  alu_op = ALU_BLT;
                    F3_BGE:  alu_op = ALU_BGE;
                    F3_BLTU: alu_op = ALU_BLTU;
                    F3_BGEU: alu_op = ALU_BGEU;
                    default: alu_op = ALU_ADD;   // reserved funct3: flag stays low, never taken
                endcase
            end
            default: ;
        endcase
    end

    islemci_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .sonuc  (alu_sonuc),
        .dallan (alu_dallan)
    );

    always_comb begin
        rd_yaz        = 1'b0;
        rd_veri       = alu_sonuc;
        sonraki_pc    = pc_arti4;
        bellek_erisim = 1'b0;
        case (opkod)
            OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: rd_yaz = 1'b1;
            OPC_JAL: begin
                rd_yaz     = 1'b1;
                rd_veri    = pc_arti4;
                sonraki_pc = pc_r + imm_r;
            end
            OPC_JALR: begin
                rd_yaz     = 1'b1;
                rd_veri    = pc_arti4;
                sonraki_pc = {alu_sonuc[31:1], 1'b0};
            end
            OPC_BRANCH: if (alu_dallan) sonraki_pc = pc_r + imm_r;
            OPC_LOAD: if (f3 == F3_WORD) begin
                rd_yaz        = 1'b1;
                rd_veri       = bellek_oku_veri;
                bellek_erisim = 1'b1;
            end
            OPC_STORE: if (f3 == F3_WORD) bellek_erisim = 1'b1;
            default: ;
        endcase
    end

    assign bellek_adres = (simdiki_asama_r == YURUTGERIYAZ && bellek_erisim)
                          ? {alu_sonuc[31:2], 2'b00} : pc_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            simdiki_asama_r <= GETIR;
            pc_r            <= BASLANGIC_ADRES;
            komut_r         <= '0;
            rs1_r           <= '0;
            rs2_r           <= '0;
            imm_r           <= '0;
            bellek_yaz      <= 1'b0;
            bellek_yaz_veri <= '0;
            for (int i = 0; i < 32; i++) yazmac_obegi[i] <= '0;
        end else begin
            case (simdiki_asama_r)
                GETIR: begin
                    komut_r         <= bellek_oku_veri;
                    simdiki_asama_r <= COZYAZMACOKU;
                end
                COZYAZMACOKU: begin
                    rs1_r <= yazmac_obegi[komut_r[19:15]];
                    rs2_r <= yazmac_obegi[komut_r[24:20]];
                    imm_r <= imm_uret(komut_r);
                    // strobe is registered so it is high for exactly the execute cycle
                    if (opkod == OPC_STORE && f3 == F3_WORD) begin
                        bellek_yaz      <= 1'b1;
                        bellek_yaz_veri <= yazmac_obegi[komut_r[24:20]];
                    end
                    simdiki_asama_r <= YURUTGERIYAZ;
                end
                YURUTGERIYAZ: begin
                    if (rd_yaz && rd != 5'd0) yazmac_obegi[rd] <= rd_veri;
                    pc_r            <= sonraki_pc;
                    bellek_yaz      <= 1'b0;
                    bellek_yaz_veri <= '0;
                    simdiki_asama_r <= GETIR;
                end
                default: simdiki_asama_r <= GETIR;
            endcase
        end
    end

endmodule

// File: tb/tb_cok_cevrimli_islemci.sv
// Scoreboard bench for cok_cevrimli_islemci: directed program, expected
// writebacks queued up front and checked by an independent monitor.
module tb_cok_cevrimli_islemci;

    localparam logic [1:0] T_GETIR = 2'd0;
    localparam logic [1:0] T_COZ   = 2'd1;
    localparam logic [1:0] T_YURUT = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bellek_adres, bellek_oku_veri, bellek_yaz_veri;
    logic        bellek_yaz;
    logic [31:0] bellek [0:255];
    logic [31:0] ofs;

    int hata = 0;
    int kontrol_sayisi = 0;

    typedef struct {
        string       isim;
        logic [4:0]  rd;
        logic [31:0] deger;
        logic [31:0] pc;
        bit          yaz;
    } beklenti_t;

    beklenti_t kuyruk[$];
    beklenti_t bas;
    int        asama_sayac = 0;
    bit        bekleyen = 0;

    always #5 clk = ~clk;

    cok_cevrimli_islemci dut (
        .clk             (clk),
        .rst             (rst),
        .bellek_adres    (bellek_adres),
        .bellek_oku_veri (bellek_oku_veri),
        .bellek_yaz_veri (bellek_yaz_veri),
        .bellek_yaz      (bellek_yaz)
    );

    assign ofs             = bellek_adres - 32'h8000_0000;
    assign bellek_oku_veri = (ofs < 32'd1024) ? bellek[ofs[9:2]] : 32'h0;

    always @(posedge clk)
        if (bellek_yaz && ofs < 32'd1024) bellek[ofs[9:2]] = bellek_yaz_veri;

    task automatic kontrol(input string isim, input logic [31:0] gercek, input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gercek !== beklenen) begin
            hata++;
            $display("FAIL %s: gercek=%h beklenen=%h", isim, gercek, beklenen);
        end
    endtask

    task automatic ekle(input string isim, input logic [4:0] rd, input logic [31:0] deger,
                        input logic [31:0] pc, input bit yaz);
        beklenti_t e;
        e.isim = isim; e.rd = rd; e.deger = deger; e.pc = pc; e.yaz = yaz;
        kuyruk.push_back(e);
    endtask

    // Monitor: stage sequence every cycle; each execute cycle pops one expectation,
    // its architectural effects are checked on the following cycle.
    always @(negedge clk) begin
        if (rst) begin
            asama_sayac = 0;
            bekleyen    = 0;
        end else begin
            if (bekleyen) begin
                bekleyen = 0;
                if (bas.yaz) kontrol({bas.isim, " bellek"}, bellek[64], bas.deger);
                else         kontrol({bas.isim, " rd"}, dut.yazmac_obegi[bas.rd], bas.deger);
                kontrol({bas.isim, " pc"}, dut.pc_r, bas.pc);
            end
            kontrol("asama", {30'b0, dut.simdiki_asama_r}, 32'(asama_sayac));
            if (dut.simdiki_asama_r == T_YURUT) begin
                if (kuyruk.size() > 0) begin
                    bas      = kuyruk.pop_front();
                    bekleyen = 1;
                    kontrol({bas.isim, " yaz"}, {31'b0, bellek_yaz}, {31'b0, bas.yaz});
                    if (bas.yaz) kontrol({bas.isim, " yaz_veri"}, bellek_yaz_veri, bas.deger);
                end else begin
                    kontrol("yaz bos", {31'b0, bellek_yaz}, 32'd0);
                end
            end else begin
                kontrol("yaz disi", {31'b0, bellek_yaz}, 32'd0);
            end
            asama_sayac = (asama_sayac + 1) % 3;
        end
    end

    task automatic kuyruk_bekle(input int sinir);
        for (int i = 0; i < sinir && kuyruk.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        kontrol("kuyruk bosaldi", 32'(kuyruk.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] program_ [0:18];
        program_ = '{
            32'hAAE00893, 32'h17200E93, 32'h52AE9637, 32'hAC7404B7,
            32'hAB7B6217, 32'h56ECA197, 32'h800002B7, 32'h10028293,
            32'h0112A023, 32'h0002A303, 32'h411E8533, 32'h4048D593,
            32'h011EB6B3, 32'h011EA733, 32'h01D8E463, 32'h00000463,
            32'h00100393, 32'h00500013, 32'hFFDFF0EF
        };
        for (int i = 0; i < 256; i++) bellek[i] = 32'h0;
        for (int i = 0; i < 19; i++) bellek[i] = program_[i];

        ekle("addi x17",  5'd17, 32'hFFFF_FAAE, 32'h8000_0004, 0);
        ekle("addi x29",  5'd29, 32'd370,       32'h8000_0008, 0);
        ekle("lui x12",   5'd12, 32'h52AE_9000, 32'h8000_000C, 0);
        ekle("lui x9",    5'd9,  32'hAC74_0000, 32'h8000_0010, 0);
        ekle("auipc x4",  5'd4,  32'h2B7B_6010, 32'h8000_0014, 0);
        ekle("auipc x3",  5'd3,  32'hD6EC_A014, 32'h8000_0018, 0);
        ekle("lui x5",    5'd5,  32'h8000_0000, 32'h8000_001C, 0);
        ekle("addi x5",   5'd5,  32'h8000_0100, 32'h8000_0020, 0);
        ekle("sw x17",    5'd0,  32'hFFFF_FAAE, 32'h8000_0024, 1);
        ekle("lw x6",     5'd6,  32'hFFFF_FAAE, 32'h8000_0028, 0);
        ekle("sub x10",   5'd10, 32'h0000_06C4, 32'h8000_002C, 0);
        ekle("srai x11",  5'd11, 32'hFFFF_FFAA, 32'h8000_0030, 0);
        ekle("sltu x13",  5'd13, 32'd1,         32'h8000_0034, 0);
        ekle("slt x14",   5'd14, 32'd0,         32'h8000_0038, 0);
        ekle("bltu nt",   5'd0,  32'd0,         32'h8000_003C, 0);
        ekle("beq +8",    5'd0,  32'd0,         32'h8000_0044, 0);
        ekle("addi x0",   5'd0,  32'd0,         32'h8000_0048, 0);
        ekle("jal x1",    5'd1,  32'h8000_004C, 32'h8000_0044, 0);

        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        kuyruk_bekle(300);
        kontrol("x7 atlandi", dut.yazmac_obegi[7], 32'h0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (dut.simdiki_asama_r == T_COZ) break;
        end
        kontrol("reset oncesi asama", {30'b0, dut.simdiki_asama_r}, {30'b0, T_COZ});
        rst = 1'b1;
        #1;
        kontrol("reset pc",    dut.pc_r, 32'h8000_0000);
        kontrol("reset asama", {30'b0, dut.simdiki_asama_r}, {30'b0, T_GETIR});
        kontrol("reset x1",    dut.yazmac_obegi[1], 32'h0);
        kontrol("reset yaz",   {31'b0, bellek_yaz}, 32'd0);
        kontrol("reset adres", bellek_adres, 32'h8000_0000);

        repeat (3) @(posedge clk);
        ekle("addi x17 r", 5'd17, 32'hFFFF_FAAE, 32'h8000_0004, 0);
        ekle("addi x29 r", 5'd29, 32'd370,       32'h8000_0008, 0);
        #2 rst = 1'b0;
        kuyruk_bekle(60);

        $display("Result: errors=%0d of %0d checks", hata, kontrol_sayisi);
        $finish;
    end

endmodule
